spi_reg_sequencer: RTL and testbench

- Command sequencer and register-file access arbiter for the SPI IO expander.
- Consumes the byte stream from the SPI shift stage and decodes command, address and data bytes with address auto-increment.
- Issues writes and prefetched reads to the 16x8 configuration/state register file.
- Shares the file's single write port with two pin-sample requesters (the P13/P20 input capture paths).

---
 rtl/spi_reg_sequencer.sv | 139 +++++++++++++
 tb/tb_spi_reg_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_sequencer.sv
// SPI command sequencer: decodes command/address/data bytes, writes and prefetch-reads the register file.
// Latency: host write 1 cycle after rx_valid; read byte tx_load 2 cycles after rx_valid.
// Backpressure: none on the SPI side; sample requesters hold smp_req until their grant pulse.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   frame_active, rx_valid,    byte stream from the SPI shift stage
//   rx_byte
//   tx_load, tx_byte           next byte for the shift stage (tx_byte qualified by tx_load)
//   rf_we/rf_waddr/rf_wdata    register-file write port (shared with sample requesters)
//   rf_raddr, rf_rdata         register-file read port, one cycle read latency
//   smp_req, smp_data0/1,      pin-sample write requesters and their one-cycle grants
//   smp_gnt
//   busy, err_cmd              status: not IDLE, unknown command pulse
module spi_reg_sequencer #(
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  CMD_WRITE = 8'hF0,
  parameter logic [7:0]  CMD_READ  = 8'h0F,
  parameter int          SMP_ADDR0 = 7,
  parameter int          SMP_ADDR1 = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              tx_load,
  output logic [7:0]        tx_byte,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [7:0]        rf_rdata,
  input  logic [1:0]        smp_req,
  input  logic [7:0]        smp_data0,
  input  logic [7:0]        smp_data1,
  output logic [1:0]        smp_gnt,
  output logic              busy,
  output logic              err_cmd
);

  localparam logic [ADDR_W-1:0] SMP_A0 = ADDR_W'(SMP_ADDR0);
  localparam logic [ADDR_W-1:0] SMP_A1 = ADDR_W'(SMP_ADDR1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WR_DATA, RD_FETCH, RD_DATA, DISCARD
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              rd_mode;
  logic              hw_vld;     // host write captured last cycle, presented this cycle
  logic [ADDR_W-1:0] hw_addr;
  logic [7:0]        hw_data;
  logic              rr;         // round-robin pointer: requester to favour when both pend
  logic              tx_done;    // the byte for this RD_DATA visit has already been loaded
  logic              rx_ok;
  logic              wr_take;
  logic              wr_keep;
  logic [1:0]        req;
  logic              sel;

  // Bytes outside a frame are ignored everywhere.
  assign rx_ok   = rx_valid & frame_active;
  assign wr_take = (state == WR_DATA) && rx_ok;
  // Sample-owned registers are read-only to the host; address still advances.
  assign wr_keep = wr_take && (addr != SMP_A0) && (addr != SMP_A1);

  assign rf_raddr = addr;
  assign tx_byte  = tx_load ? rf_rdata : 8'h00;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    tx_load   = (state == RD_DATA) && !tx_done && frame_active;
    if (!frame_active) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = CMD;
        CMD:      if (rx_valid) state_nxt = ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ)) ? ADDR : DISCARD;
        ADDR:     if (rx_valid) state_nxt = rd_mode ? RD_FETCH : WR_DATA;
        WR_DATA:  state_nxt = WR_DATA;
        RD_FETCH: state_nxt = RD_DATA;
        RD_DATA:  if (rx_valid) state_nxt = RD_FETCH;
        DISCARD:  state_nxt = DISCARD;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Write-port arbitration: the registered host write always wins; samples fill idle cycles.
  always_comb begin
    req      = rst_n ? smp_req : 2'b00;
    sel      = (req == 2'b11) ? rr : req[1];
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = 8'h00;
    smp_gnt  = 2'b00;
    if (hw_vld) begin
      rf_we    = 1'b1;
      rf_waddr = hw_addr;
      rf_wdata = hw_data;
    end else if (req != 2'b00) begin
      rf_we        = 1'b1;
      smp_gnt[sel] = 1'b1;
      rf_waddr     = sel ? SMP_A1 : SMP_A0;
      rf_wdata     = sel ? smp_data1 : smp_data0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      rd_mode <= 1'b0;
      hw_vld  <= 1'b0;
      hw_addr <= '0;
      hw_data <= 8'h00;
      rr      <= 1'b0;
      tx_done <= 1'b0;
      err_cmd <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_cmd <= (state == CMD) && rx_ok && (rx_byte != CMD_WRITE) && (rx_byte != CMD_READ);
      if ((state == CMD) && rx_ok) rd_mode <= (rx_byte == CMD_READ);
      hw_vld <= wr_keep;
      if (wr_take) begin
        hw_addr <= addr;
        hw_data <= rx_byte;
      end
      if ((state == ADDR) && rx_ok) addr <= rx_byte[ADDR_W-1:0];
      else if (wr_take || tx_load)  addr <= addr + ADDR_W'(1);
      tx_done <= (state == RD_DATA) && (state_nxt == RD_DATA);
      if (!hw_vld && (smp_req == 2'b11)) rr <= ~rr;
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic [1:0] smp_req;
  logic [7:0] smp_data0;
  logic [7:0] smp_data1;
  logic [1:0] smp_gnt;
  logic       busy;
  logic       err_cmd;

  spi_reg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_load(tx_load), .tx_byte(tx_byte),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .smp_req(smp_req), .smp_data0(smp_data0), .smp_data1(smp_data1),
    .smp_gnt(smp_gnt), .busy(busy), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file seen by the DUT (cleared by reset so every test starts from a known image).
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    rf_rdata <= rf_mem[rf_raddr];
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  // Model state: expected events indexed by cycle, and the model's own register image.
  bit         exp_hw  [1024];
  logic [3:0] exp_hwa [1024];
  logic [7:0] exp_hwd [1024];
  bit         exp_tx  [1024];
  logic [7:0] exp_txd [1024];
  bit         exp_err [1024];
  logic [7:0] m_mem   [16];
  logic       m_rr;
  logic       prev_rst, prev_fa;
  logic [1:0] gnt_seen;
  bit         chk_en;
  int         arm_cyc;
  int         checks, errors;
  int         obs_tx, obs_err, obs_g0, obs_g1;
  logic [7:0] fb [8];
  int         md;
  logic [3:0] ma;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one frame of n bytes from fb[]; abort=1 drops the frame right after the last
  // byte, abort=2 also pulses reset then. req_byte arms both sample requests one cycle
  // after that byte.
  task automatic do_frame(input int n, input int abort, input int req_byte);
    int c;
    bit last_ab;
    frame_active = 1'b1;
    tick; tick;
    md = 0;
    for (int k = 0; k < n; k++) begin
      last_ab  = (k == n - 1) && (abort != 0);
      rx_valid = 1'b1;
      rx_byte  = fb[k];
      c        = cyc;
      if (k == req_byte) arm_cyc = c + 1;
      if (k == 0) begin
        if (fb[k] == 8'hF0)      md = 1;
        else if (fb[k] == 8'h0F) md = 2;
        else begin md = 3; exp_err[c+1] = 1'b1; end
      end else if (k == 1 && md != 3) begin
        ma = fb[k][3:0];
        if (md == 2 && !last_ab) begin
          exp_tx[c+2] = 1'b1; exp_txd[c+2] = m_mem[ma]; ma = ma + 4'd1;
        end
      end else if (md == 1) begin
        if (ma != 4'd7 && ma != 4'd9) begin
          exp_hw[c+1] = 1'b1; exp_hwa[c+1] = ma; exp_hwd[c+1] = fb[k];
        end
        ma = ma + 4'd1;
      end else if (md == 2 && !last_ab) begin
        exp_tx[c+2] = 1'b1; exp_txd[c+2] = m_mem[ma]; ma = ma + 4'd1;
      end
      tick;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      if (last_ab) begin
        frame_active = 1'b0;
        if (abort == 2) rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        if (abort == 2) begin
          chk("rst_busy", busy, 0);
          chk("rst_we", rf_we, 0);
          chk("rst_tx", tx_load, 0);
          chk("rst_gnt", smp_gnt, 0);
          chk("rst_err", err_cmd, 0);
        end
      end
      tick; tick; tick;
    end
    if (abort == 0) begin
      tick; tick;
      frame_active = 1'b0;
    end
    tick; tick; tick;
  endtask

  initial begin
    rst_n = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    smp_req = 2'b00; smp_data0 = 8'h5A; smp_data1 = 8'hC3;
    checks = 0; errors = 0; obs_tx = 0; obs_err = 0; obs_g0 = 0; obs_g1 = 0;
    chk_en = 0; arm_cyc = -1; m_rr = 1'b0; prev_rst = 1'b0; prev_fa = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

    fork
      // Sample requesters: raise both on the armed cycle, drop each after its grant.
      forever begin
        @(negedge clk);
        gnt_seen = smp_gnt;
        @(posedge clk);
        #1;
        smp_req = smp_req & ~gnt_seen;
        if (cyc == arm_cyc) smp_req = 2'b11;
      end
      // Per-cycle comparison against the model.
      forever begin : compare
        logic [1:0] e_g;
        logic       e_we;
        logic [3:0] e_wa;
        logic [7:0] e_wd;
        int         n;
        @(negedge clk);
        n   = cyc;
        e_g = 2'b00;
        if (rst_n && !exp_hw[n]) begin
          case (smp_req)
            2'b01: e_g = 2'b01;
            2'b10: e_g = 2'b10;
            2'b11: begin e_g = m_rr ? 2'b10 : 2'b01; m_rr = ~m_rr; end
            default: e_g = 2'b00;
          endcase
        end
        e_we = exp_hw[n] || (e_g != 2'b00);
        e_wa = exp_hw[n] ? exp_hwa[n] : (e_g[1] ? 4'd9 : 4'd7);
        e_wd = exp_hw[n] ? exp_hwd[n] : (e_g[1] ? smp_data1 : smp_data0);
        if (chk_en) begin
          chk("busy", busy, prev_rst && prev_fa);
          chk("rf_we", rf_we, e_we);
          if (e_we) begin
            chk("rf_waddr", rf_waddr, e_wa);
            chk("rf_wdata", rf_wdata, e_wd);
          end
          chk("tx_load", tx_load, exp_tx[n]);
          if (exp_tx[n]) chk("tx_byte", tx_byte, exp_txd[n]);
          chk("err_cmd", err_cmd, exp_err[n]);
          chk("smp_gnt", smp_gnt, e_g);
          if (tx_load)    obs_tx++;
          if (err_cmd)    obs_err++;
          if (smp_gnt[0]) obs_g0++;
          if (smp_gnt[1]) obs_g1++;
        end
        if (e_we) m_mem[e_wa] = e_wd;
        if (!rst_n) begin
          m_rr = 1'b0;
          for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end
        prev_rst = rst_n;
        prev_fa  = frame_active;
      end
    join_none

    tick; tick; tick;
    chk("reset_busy", busy, 0);
    chk("reset_we", rf_we, 0);
    chk("reset_tx", tx_load, 0);
    chk("reset_gnt", smp_gnt, 0);
    chk("reset_err", err_cmd, 0);
    rst_n = 1'b1;
    chk_en = 1;
    tick; tick;

    fb[0] = 8'hF0; fb[1] = 8'h03; fb[2] = 8'hAA; fb[3] = 8'h55;
    do_frame(4, 0, -1);
    fb[0] = 8'hF0; fb[1] = 8'h0F; fb[2] = 8'h11; fb[3] = 8'h22;
    do_frame(4, 0, -1);
    fb[0] = 8'h0F; fb[1] = 8'h0F; fb[2] = 8'h00; fb[3] = 8'h00;
    do_frame(4, 0, -1);
    fb[0] = 8'h3C; fb[1] = 8'h01; fb[2] = 8'hFF;
    do_frame(3, 0, -1);
    fb[0] = 8'hF0; fb[1] = 8'h00; fb[2] = 8'h10; fb[3] = 8'h20; fb[4] = 8'h30; fb[5] = 8'h40;
    do_frame(6, 0, 2);
    fb[0] = 8'hF0; fb[1] = 8'h06; fb[2] = 8'h01; fb[3] = 8'h02; fb[4] = 8'h03;
    do_frame(5, 0, -1);
    fb[0] = 8'h0F; fb[1] = 8'h05;
    do_frame(2, 1, -1);

    // Hand-computed register image and event counts.
    chk("lit_rf0",  rf_mem[0],  8'h10);  chk("lit_m0",  m_mem[0],  8'h10);
    chk("lit_rf3",  rf_mem[3],  8'h40);  chk("lit_m3",  m_mem[3],  8'h40);
    chk("lit_rf4",  rf_mem[4],  8'h55);  chk("lit_m4",  m_mem[4],  8'h55);
    chk("lit_rf15", rf_mem[15], 8'h11);  chk("lit_m15", m_mem[15], 8'h11);
    chk("lit_rf6",  rf_mem[6],  8'h01);  chk("lit_m6",  m_mem[6],  8'h01);
    chk("lit_rf7",  rf_mem[7],  8'h5A);  chk("lit_m7",  m_mem[7],  8'h5A);
    chk("lit_rf8",  rf_mem[8],  8'h03);  chk("lit_m8",  m_mem[8],  8'h03);
    chk("lit_rf9",  rf_mem[9],  8'hC3);  chk("lit_m9",  m_mem[9],  8'hC3);
    chk("lit_tx_count",  obs_tx,  3);
    chk("lit_err_count", obs_err, 1);
    chk("lit_g0_count",  obs_g0,  1);
    chk("lit_g1_count",  obs_g1,  1);

    fb[0] = 8'hF0; fb[1] = 8'h0A; fb[2] = 8'h77;
    do_frame(3, 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
